// File: rtl/tinytpu_pkg.sv
// rtl/tinytpu_pkg.sv - shared sequencer state encoding, default sizes and stream length
// Optional feature macro: TINYTPU_SEQ_CTRL_PARITY_EN (adds one even-parity bit to the result stream).
package tinytpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_READY   = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_TX      = 3'd5
  } seq_state_t;

  localparam int DEF_D_W   = 8;
  localparam int DEF_N     = 2;
  localparam int DEF_ACC_W = 2 * DEF_D_W;

`ifdef TINYTPU_SEQ_CTRL_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Number of tx_ready cycles for one result: all accumulators plus the optional parity bit.
  function automatic int stream_len(input int n, input int acc_w);
    return n * n * acc_w + PARITY_BITS;
  endfunction

endpackage

// File: rtl/tinytpu_skew_feed.sv
// rtl/tinytpu_skew_feed.sv - diagonal wavefront selection of A rows and B columns
// Optional feature macro: TINYTPU_SEQ_CTRL_PARITY_EN (not used in this file).
module tinytpu_skew_feed
  import tinytpu_pkg::*;
#(
  parameter int D_W = DEF_D_W,
  parameter int N   = DEF_N,
  parameter int SCW = 2
) (
  input  logic                 i_en,
  input  logic [SCW-1:0]       i_step,
  input  logic [N*N*D_W-1:0]   i_buf_a,
  input  logic [N*N*D_W-1:0]   i_buf_b,
  output logic [N*D_W-1:0]     o_a_row,
  output logic [N*D_W-1:0]     o_b_col
);

  // Row i / column i lag the wavefront by i steps so A[i][k] meets B[k][j] at PE(i,j).
  always_comb begin
    o_a_row = '0;
    o_b_col = '0;
    if (i_en) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(i_step) >= i) && ((int'(i_step) - i) < N)) begin
          o_a_row[i*D_W +: D_W] = i_buf_a[(i*N + int'(i_step) - i)*D_W +: D_W];
          o_b_col[i*D_W +: D_W] = i_buf_b[((int'(i_step) - i)*N + i)*D_W +: D_W];
        end
      end
    end
  end

endmodule

// File: rtl/tinytpu_seq_ctrl.sv
// rtl/tinytpu_seq_ctrl.sv - serial load, skewed compute feed and serial result sequencer
// Optional feature macro: TINYTPU_SEQ_CTRL_PARITY_EN (appends an even-parity bit after the result bits).
module tinytpu_seq_ctrl
  import tinytpu_pkg::*;
#(
  parameter int D_W   = DEF_D_W,
  parameter int N     = DEF_N,
  parameter int ACC_W = 2 * D_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_in_x,
  input  logic                   data_in_y,
  input  logic                   load_en,
  input  logic                   init,
  output logic [N*D_W-1:0]       a_row,
  output logic [N*D_W-1:0]       b_col,
  output logic                   arr_clr,
  output logic                   arr_en,
  input  logic [N*N*ACC_W-1:0]   acc_in,
  output logic                   data_out_z,
  output logic                   tx_ready,
  output logic                   busy
);

  localparam int LOAD_BITS = N * N * D_W;
  localparam int RES_BITS  = N * N * ACC_W;
  localparam int TX_BITS   = stream_len(N, ACC_W);
  localparam int STEPS     = 3 * N - 2;
  localparam int LCW       = (LOAD_BITS > 1) ? $clog2(LOAD_BITS) : 1;
  localparam int TCW       = (TX_BITS > 1) ? $clog2(TX_BITS) : 1;
  localparam int SCW       = (STEPS > 1) ? $clog2(STEPS) : 1;

  seq_state_t           r_state;
  logic [LCW-1:0]       r_ld_cnt;
  logic [SCW-1:0]       r_step;
  logic [TCW-1:0]       r_tx_cnt;
  logic [LOAD_BITS-1:0] r_buf_a;
  logic [LOAD_BITS-1:0] r_buf_b;
  logic [RES_BITS-1:0]  r_snap;
  logic                 r_arr_clr;
  logic                 r_arr_en;
  logic                 r_tx_ready;
  logic                 r_busy;
`ifdef TINYTPU_SEQ_CTRL_PARITY_EN
  logic                 r_par;
`endif

  logic [LOAD_BITS-1:0] w_buf_a_next;
  logic [LOAD_BITS-1:0] w_buf_b_next;
  logic                 w_feed_en;
  logic                 w_tx_bit;

  // New bits enter at the top so the first bit received ends up at bit 0 (element 0, LSB).
  assign w_buf_a_next = {data_in_x, r_buf_a[LOAD_BITS-1:1]};
  assign w_buf_b_next = {data_in_y, r_buf_b[LOAD_BITS-1:1]};
  assign w_feed_en    = (r_state == ST_COMPUTE);

  tinytpu_skew_feed #(
    .D_W (D_W),
    .N   (N),
    .SCW (SCW)
  ) u_skew_feed (
    .i_en    (w_feed_en),
    .i_step  (r_step),
    .i_buf_a (r_buf_a),
    .i_buf_b (r_buf_b),
    .o_a_row (a_row),
    .o_b_col (b_col)
  );

`ifdef TINYTPU_SEQ_CTRL_PARITY_EN
  assign w_tx_bit = (r_tx_cnt == TCW'(RES_BITS)) ? r_par : r_snap[0];
`else
  assign w_tx_bit = r_snap[0];
`endif

  assign arr_clr    = r_arr_clr;
  assign arr_en     = r_arr_en;
  assign tx_ready   = r_tx_ready;
  assign busy       = r_busy;
  assign data_out_z = r_tx_ready & w_tx_bit;

  // Sequencer: load -> wait for init -> clear -> skewed compute -> snapshot -> serial transmit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ld_cnt   <= '0;
      r_step     <= '0;
      r_tx_cnt   <= '0;
      r_buf_a    <= '0;
      r_buf_b    <= '0;
      r_snap     <= '0;
      r_arr_clr  <= 1'b0;
      r_arr_en   <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
`ifdef TINYTPU_SEQ_CTRL_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_en) begin
            r_buf_a  <= w_buf_a_next;
            r_buf_b  <= w_buf_b_next;
            r_ld_cnt <= LCW'(1);
            r_busy   <= 1'b1;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // load_en low simply pauses; there is no timeout.
          if (load_en) begin
            r_buf_a <= w_buf_a_next;
            r_buf_b <= w_buf_b_next;
            if (r_ld_cnt == LCW'(LOAD_BITS - 1)) begin
              r_ld_cnt <= '0;
              r_state  <= ST_READY;
            end else begin
              r_ld_cnt <= r_ld_cnt + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (init) begin
            r_arr_clr <= 1'b1;
            r_state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_arr_clr <= 1'b0;
          r_arr_en  <= 1'b1;
          r_step    <= '0;
          r_state   <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (r_step == SCW'(STEPS - 1)) begin
            r_arr_en <= 1'b0;
            r_step   <= '0;
            r_state  <= ST_TX;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        ST_TX: begin
          // First TX cycle only captures acc_in, which now includes the last compute step.
          if (!r_tx_ready) begin
            r_snap     <= acc_in;
            r_tx_ready <= 1'b1;
            r_tx_cnt   <= '0;
`ifdef TINYTPU_SEQ_CTRL_PARITY_EN
            r_par      <= 1'b0;
`endif
          end else if (r_tx_cnt == TCW'(TX_BITS - 1)) begin
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= '0;
            r_snap     <= '0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
            r_snap   <= {1'b0, r_snap[RES_BITS-1:1]};
`ifdef TINYTPU_SEQ_CTRL_PARITY_EN
            r_par    <= r_par ^ r_snap[0];
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinytpu_seq_ctrl.sv
// tb/tb_tinytpu_seq_ctrl.sv - self-checking bench for tinytpu_seq_ctrl with a behavioural array
// Optional feature macro: TINYTPU_SEQ_CTRL_PARITY_EN (bench expects the extra parity bit when defined).
module tb_tinytpu_seq_ctrl;
  import tinytpu_pkg::*;

  localparam int D_W      = DEF_D_W;
  localparam int N        = DEF_N;
  localparam int ACC_W    = DEF_ACC_W;
  localparam int NE       = N * N;
  localparam int RES_BITS = NE * ACC_W;
`ifdef TINYTPU_SEQ_CTRL_PARITY_EN
  localparam int EXP_TX = RES_BITS + 1;
`else
  localparam int EXP_TX = RES_BITS;
`endif

  typedef logic [NE*D_W-1:0]   mat_t;
  typedef logic [NE*ACC_W-1:0] res_t;
  typedef struct packed {
    mat_t a;
    mat_t b;
    res_t c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_in_x = 1'b0;
  logic data_in_y = 1'b0;
  logic load_en = 1'b0;
  logic init = 1'b0;
  logic [N*D_W-1:0] a_row, b_col;
  logic arr_clr, arr_en, data_out_z, tx_ready, busy;
  logic [NE*ACC_W-1:0] acc_in;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  tinytpu_seq_ctrl #(.D_W(D_W), .N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_in_x(data_in_x), .data_in_y(data_in_y),
    .load_en(load_en), .init(init), .a_row(a_row), .b_col(b_col),
    .arr_clr(arr_clr), .arr_en(arr_en), .acc_in(acc_in),
    .data_out_z(data_out_z), .tx_ready(tx_ready), .busy(busy)
  );

  // Behavioural output-stationary array: A flows right, B flows down, each PE accumulates.
  logic [ACC_W-1:0] m_acc [N][N];
  logic [D_W-1:0]   m_a   [N][N];
  logic [D_W-1:0]   m_b   [N][N];

  function automatic logic [D_W-1:0] pe_a(input int i, input int j);
    return (j == 0) ? a_row[i*D_W +: D_W] : m_a[i][(j+N-1)%N];
  endfunction

  function automatic logic [D_W-1:0] pe_b(input int i, input int j);
    return (i == 0) ? b_col[j*D_W +: D_W] : m_b[(i+N-1)%N][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_clr) begin
          m_acc[i][j] <= '0;
          m_a[i][j]   <= '0;
          m_b[i][j]   <= '0;
        end else if (arr_en) begin
          m_acc[i][j] <= m_acc[i][j] + ACC_W'(pe_a(i, j)) * ACC_W'(pe_b(i, j));
          m_a[i][j]   <= pe_a(i, j);
          m_b[i][j]   <= pe_b(i, j);
        end
      end
    end
  end

  always_comb begin
    acc_in = '0;
    for (int e = 0; e < NE; e++) acc_in[e*ACC_W +: ACC_W] = m_acc[e/N][e%N];
  end

  // Feed monitor: records a_row/b_col per compute step and counts strobes.
  int mon_step = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int idle_bad = 0;
  logic [N*D_W-1:0] fa [8];
  logic [N*D_W-1:0] fb [8];

  always @(negedge clk) begin
    if (arr_clr) begin
      clr_cnt  <= clr_cnt + 1;
      mon_step <= 0;
    end
    if (arr_en) begin
      if (mon_step < 8) begin
        fa[mon_step] <= a_row;
        fb[mon_step] <= b_col;
      end
      mon_step <= mon_step + 1;
      en_cnt   <= en_cnt + 1;
    end
    if (!arr_en && ((a_row != '0) || (b_col != '0))) idle_bad <= idle_bad + 1;
  end

  // Reference: plain matrix product, truncated to ACC_W per element.
  function automatic res_t ref_mm(input mat_t a, input mat_t b);
    res_t c;
    int s;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s = s + int'(a[(i*N+k)*D_W +: D_W]) * int'(b[(k*N+j)*D_W +: D_W]);
        c[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(s);
      end
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a_row"}, 64'(a_row), 64'd0);
    chk({nm, "_b_col"}, 64'(b_col), 64'd0);
    chk({nm, "_strobes"}, {59'd0, arr_clr, arr_en, data_out_z, tx_ready, busy}, 64'd0);
  endtask

  // Called and returns just after a falling edge; mode 0 dense, 1 alternate, 2 random gaps.
  task automatic do_load(input mat_t a, input mat_t b, input int mode, input bit init_poke);
    int gaps;
    for (int k = 0; k < NE*D_W; k++) begin
      data_in_x = a[k];
      data_in_y = b[k];
      load_en   = 1'b1;
      init      = init_poke && ((k == 10) || (k == NE*D_W-1));
      @(negedge clk);
      init = 1'b0;
      gaps = (mode == 1) ? 1 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
      repeat (gaps) begin
        load_en   = 1'b0;
        data_in_x = 1'($urandom);
        data_in_y = 1'($urandom);
        @(negedge clk);
      end
    end
    load_en   = 1'b0;
    data_in_x = 1'b0;
    data_in_y = 1'b0;
  endtask

  task automatic run_tx(output res_t got, output int ntx, output logic pbit,
                        input bit disturb, input int stop_at);
    bit seen;
    bit done;
    seen = 1'b0;
    done = 1'b0;
    got  = '0;
    ntx  = 0;
    pbit = 1'b0;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (tx_ready) begin
        if (ntx < RES_BITS) got[ntx] = data_out_z;
        else pbit = data_out_z;
        ntx++;
        seen = 1'b1;
        if (stop_at > 0 && ntx == stop_at) done = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
      if (!done) begin
        if (disturb) begin
          if (!seen) begin
            load_en   = 1'b1;
            data_in_x = 1'($urandom);
            data_in_y = 1'($urandom);
            init      = 1'b0;
          end else begin
            load_en = 1'b0;
            init    = 1'b1;
          end
        end
        @(negedge clk);
      end
    end
    load_en = 1'b0;
    init    = 1'b0;
    chk("tx_completed", 64'(done), 64'd1);
  endtask

  task automatic run_check(input string nm, input res_t exp, input bit disturb);
    res_t got;
    int ntx;
    logic pbit;
    int en0;
    int clr0;
    en0  = en_cnt;
    clr0 = clr_cnt;
    run_tx(got, ntx, pbit, disturb, 0);
    for (int e = 0; e < NE; e++)
      chk($sformatf("%s_c%0d", nm, e), 64'(got[e*ACC_W +: ACC_W]), 64'(exp[e*ACC_W +: ACC_W]));
    chk({nm, "_tx_len"}, 64'(ntx), 64'(EXP_TX));
    chk({nm, "_en_cycles"}, 64'(en_cnt - en0), 64'(3*N-2));
    chk({nm, "_clr_pulses"}, 64'(clr_cnt - clr0), 64'd1);
`ifdef TINYTPU_SEQ_CTRL_PARITY_EN
    chk({nm, "_parity"}, 64'(pbit), 64'(^exp));
`endif
    chk({nm, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  vec_t vecs [4];

  initial begin
    mat_t ra;
    mat_t rb;
    res_t got;
    int ntx;
    logic pbit;
    int clr0;

    vecs[0] = '{a: 32'h04030201, b: 32'h08070605, c: 64'h0032_002B_0016_0013};
    vecs[1] = '{a: 32'h01000001, b: 32'h034DC809, c: 64'h0003_004D_00C8_0009};
    vecs[2] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, c: 64'hFC02_FC02_FC02_FC02};
    vecs[3] = '{a: 32'h03000002, b: 32'h07060504, c: 64'h0015_0012_000A_0008};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // init while idle must not start anything
    clr0 = clr_cnt;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_init_busy", 64'(busy), 64'd0);
    chk("idle_init_clr", 64'(clr_cnt - clr0), 64'd0);

    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].a, vecs[v].b, 0, 1'b0);
      chk($sformatf("vec%0d_ready_busy", v), 64'(busy), 64'd1);
      run_check($sformatf("vec%0d", v), vecs[v].c, 1'b0);
      if (v == 0) begin
        chk("feed_t0_a", 64'(fa[0]), 64'h0001);
        chk("feed_t0_b", 64'(fb[0]), 64'h0005);
        chk("feed_t1_a", 64'(fa[1]), 64'h0302);
        chk("feed_t1_b", 64'(fb[1]), 64'h0607);
        chk("feed_t3_a", 64'(fa[3]), 64'h0000);
        chk("feed_t3_b", 64'(fb[3]), 64'h0000);
      end
    end

    // load_en toggling every other cycle
    do_load(vecs[0].a, vecs[0].b, 1, 1'b0);
    chk("gap_ready_busy", 64'(busy), 64'd1);
    run_check("gap", vecs[0].c, 1'b0);

    // init mid-load and together with the final bit
    clr0 = clr_cnt;
    do_load(vecs[3].a, vecs[3].b, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("poke_clr", 64'(clr_cnt - clr0), 64'd0);
    chk("poke_busy", 64'(busy), 64'd1);
    run_check("poke", vecs[3].c, 1'b0);

    // load_en during clear/compute and init throughout TX
    do_load(vecs[1].a, vecs[1].b, 0, 1'b0);
    run_check("disturb", vecs[1].c, 1'b1);
    do_load(vecs[0].a, vecs[0].b, 0, 1'b0);
    run_check("after_disturb", vecs[0].c, 1'b0);

    for (int r = 0; r < 6; r++) begin
      ra = mat_t'($urandom);
      rb = mat_t'($urandom);
      do_load(ra, rb, 2, 1'b0);
      run_check($sformatf("rand%0d", r), ref_mm(ra, rb), 1'b0);
    end

    // asynchronous reset at TX bit 10, then an immediate fresh load
    do_load(vecs[0].a, vecs[0].b, 0, 1'b0);
    run_tx(got, ntx, pbit, 1'b0, 10);
    chk("rst_bits_before", 64'(ntx), 64'd10);
    chk("rst_partial_bits", 64'(got[9:0]), 64'(vecs[0].c[9:0]));
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_tx");
    @(negedge clk);
    chk_zero("rst_held");
    rst_n = 1'b1;
    do_load(vecs[2].a, vecs[2].b, 0, 1'b0);
    chk("post_rst_busy", 64'(busy), 64'd1);
    run_check("post_rst", vecs[2].c, 1'b0);

    chk("feed_zero_outside_compute", 64'(idle_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tinytpu_seq_ctrl.md
TINYTPU_SEQ_CTRL -- requirements
Module: tinytpu_seq_ctrl

Interface
REQ-001 SHALL have parameter D_W, default 8: operand width in bits.
REQ-002 SHALL have parameter N, default 2: array dimension (N x N).
REQ-003 SHALL have parameter ACC_W, default 2*D_W: result element width.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have ports data_in_x and data_in_y, input, 1 each: serial A and B operand bits, LSB first.
REQ-007 SHALL have port load_en, input, 1: qualifies data_in_x/data_in_y in the current cycle.
REQ-008 SHALL have port init, input, 1: start-compute request.
REQ-009 SHALL have port a_row, output, N*D_W: skewed A operands, row i at bits [i*D_W +: D_W].
REQ-010 SHALL have port b_col, output, N*D_W: skewed B operands, column j at bits [j*D_W +: D_W].
REQ-011 SHALL have ports arr_clr and arr_en, output, 1 each: accumulator clear and array advance.
REQ-012 SHALL have port acc_in, input, N*N*ACC_W: array results, element (i,j) at index i*N+j.
REQ-013 SHALL have ports data_out_z, tx_ready and busy, output, 1 each: serial result bit, result-bit valid, and not-IDLE indication.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, READY, CLEAR, COMPUTE, TX.
REQ-015 SHALL, in IDLE or LOAD, shift one x bit and one y bit per cycle with load_en=1 into A/B buffers, row-major, element 0 first, LSB first; IDLE->LOAD on the first bit.
REQ-016 SHALL hold state and bit counter when load_en=0 in LOAD (pause, no timeout).
REQ-017 SHALL go LOAD->READY in the cycle the N*N*D_W-th bit is accepted (32 bits at defaults).
REQ-018 SHALL ignore load_en in READY, CLEAR, COMPUTE and TX, and ignore init in every state except READY.
REQ-019 SHALL go READY->CLEAR on init=1; CLEAR lasts 1 cycle with arr_clr=1, arr_en=0.
REQ-020 SHALL hold COMPUTE for exactly 3N-2 cycles with arr_en=1, step counter t=0..3N-3.
REQ-021 SHALL drive, at step t, row i = A[i][t-i] and column j = B[t-j][j] when 0<=t-i<N (resp. 0<=t-j<N), else 0; a_row/b_col = 0 outside COMPUTE.
REQ-022 SHALL snapshot acc_in in the cycle after the last COMPUTE step and enter TX.
REQ-023 SHALL, in TX, emit N*N*ACC_W bits on data_out_z, element 0 first, LSB first, one bit per cycle with tx_ready=1, then return to IDLE; data_out_z=0 when tx_ready=0.
REQ-024 SHALL treat init arriving in the same cycle as the final load bit as ignored (READY not yet entered).

Reset
REQ-025 SHALL on rst_n=0, at any time including mid-LOAD/COMPUTE/TX, enter IDLE, clear counters, buffers and snapshot, and drive all outputs 0.
REQ-026 SHALL accept a new load sequence in the first cycle after rst_n deasserts.

Configuration
REQ-027 SHALL, with TINYTPU_SEQ_CTRL_PARITY_EN defined, append one even-parity bit over the whole TX stream (tx_ready=1) before IDLE; without it, the stream is exactly N*N*ACC_W bits.

Structure
REQ-028 SHALL take the FSM state enum, default D_W/N/ACC_W constants and the stream-length function from shared package tinytpu_pkg.
REQ-029 SHALL place the REQ-021 skew/select logic in sub-module tinytpu_skew_feed.

Verification
REQ-030 SHALL cover: A=[[1,2],[3,4]], B=[[5,6],[7,8]] loaded in 32 cycles, init, behavioural array model -> serial result 19,22,43,50 (16 bits each), tx_ready high 64 cycles.
REQ-031 SHALL cover: same load with load_en toggling every other cycle -> READY after 32 accepted bits, identical result.
REQ-032 SHALL cover: step-wise feed check -> t=0 a_row={0,1}, b_col={0,5}; t=1 a_row={3,2}, b_col={6,7}; t=3 both 0; arr_en high exactly 4 cycles.
REQ-033 SHALL cover: init in IDLE, mid-LOAD and during TX, plus load_en during COMPUTE -> no state change, no buffer corruption.
REQ-034 SHALL cover: rst_n low at TX bit 10 -> outputs 0 immediately, IDLE, fresh load then gives correct result.
REQ-035 SHALL cover, with TINYTPU_SEQ_CTRL_PARITY_EN: REQ-030 data -> 65 tx_ready cycles, final bit equals XOR of the 64 result bits.
